prime_sink: RTL and testbench
=============================

// Module: prime_sink
// PURPOSE
//  Consumer end of the sieve result stream: captures each reported value (in__rdy strobe + in__addr),
//  buffers it in a small FIFO and re-emits it on a valid/take output handshake.
//  Keeps a running count and mod-2^W checksum of accepted values, and signals completion once in__done
//  is seen and the buffer has drained. Sits between the sieve block and the host/readout logic.
// PARAMETERS
//  W      8   data width of in__addr / out__dout / out__sum
//  DEPTH  8   FIFO entries (power of 2, >=2)
//  CNT_W  8   width of out__count
// PORTS
//  clk            in   1      clock; all logic on posedge
//  rst            in   1      reset, synchronous, active-high
//  in__rdy        in   1      producer strobe: one value per high cycle
//  in__addr       in   W      value presented while in__rdy=1
//  in__done       in   1      producer end-of-stream (level, stays high)
//  in__take       in   1      consumer accepts out__dout this cycle
//  out__valid     out  1      out__dout holds an undelivered value
//  out__dout      out  W      FIFO head value
//  out__count     out  CNT_W  number of values accepted into FIFO (saturates at all-ones)
//  out__sum       out  W      sum of accepted values mod 2^W
//  out__overflow  out  1      sticky: a strobe was dropped (FIFO full, no pop)
//  out__proto_err out  1      sticky: strobe arrived after end-of-stream
//  out__done      out  1      stream ended and FIFO empty; held until reset
// BEHAVIOUR
//  Reset (sync, active-high, rst wins over all): FIFO empty, state=COLLECT, every output 0
//   (out__dout=0 when empty). rst mid-stream discards buffered data and all sticky flags.
//  Push: in__rdy=1 in COLLECT or DRAIN-entry cycle (see below) and (not full or pop this cycle).
//  Pop: out__valid=1 and in__take=1. in__take with out__valid=0 is ignored.
//  Latency: value strobed in cycle N appears on out__dout with out__valid=1 from cycle N+1
//   if FIFO was empty; no bypass in cycle N. out__dout stable while out__valid=1 and no pop.
//  Full + push + pop same cycle: both succeed, occupancy unchanged. Full + push, no pop: value
//   dropped, out__overflow<=1, count/sum unchanged. Empty + push + take same cycle: push only.
//  count/sum update in cycle after the accepted push; sum wraps mod 2^W; count saturates.
//  State machine (2-bit):
//   COLLECT  : accept strobes; in__done=1 -> DRAIN (strobe in that same cycle still accepted)
//   DRAIN    : no pushes; in__rdy=1 -> out__proto_err<=1, value discarded; FIFO empty and
//              no push pending -> FINISHED
//   FINISHED : out__done=1; out__valid=0; strobes set out__proto_err; stays until rst
//  in__done=1 while FIFO already empty in COLLECT: DRAIN for one cycle, FINISHED next
//   (out__done asserted 2 cycles after in__done if no strobe).
//  Pointers: log2(DEPTH)+1 bits, wrap naturally; full = MSB differ & rest equal.
// STRUCTURE
//  Shared package/include: state encodings (ST_COLLECT=0, ST_DRAIN=1, ST_FINISHED=2), default W.
//  One sub-module: sync_fifo (W, DEPTH; push/pop/full/empty/head, registered storage).
//  Top holds FSM, counters, sticky flags and drop logic.
// TESTING
//  1 Feed 25 primes 2..97 one per 2 cycles, in__take=1 always, then in__done ->
//    25 values out in order, out__count=25, out__sum=8'd36 (1060 mod 256), out__done=1, flags 0.
//  2 in__take=0, 10 back-to-back strobes 1..10 (DEPTH=8) -> out__overflow=1, count=8,
//    then take all -> 1..8 delivered, 9/10 absent, sum=36.
//  3 FIFO full, strobe + take same cycle -> no overflow, occupancy stays 8, new value at tail.
//  4 in__done with 3 entries buffered, take one per 4 cycles -> out__done only after 3rd pop;
//    strobe during DRAIN sets out__proto_err, value not delivered.
//  5 rst asserted with 5 entries buffered and overflow set -> next cycle all outputs 0,
//    state COLLECT; fresh stream then works as scenario 1.
//  6 in__done with no data ever -> out__done=1 two cycles later, count=0, sum=0.

Source files
------------

// File: rtl/prime_sink_pkg.sv
// Shared definitions for the prime_sink block: FSM state encodings and default data width.
package prime_sink_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_FINISHED = 2'd2
  } state_t;

endpackage

// File: rtl/prime_sink_sync_fifo.sv
// Small synchronous FIFO with registered storage. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter. The caller is
// responsible for only pushing when there is room (or a pop in the same cycle) and only
// popping when not empty.
module prime_sink_sync_fifo
  import prime_sink_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers; they wrap naturally through the extra MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write the incoming value at the tail. When full with a simultaneous pop, the tail slot is
  // the one being vacated by the head, which was already read combinationally this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/prime_sink.sv
// Consumer end of the sieve result stream. Buffers strobed values in a FIFO, re-emits them on
// a valid/take handshake, keeps a saturating count and a wrapping checksum of accepted
// values, and reports completion once end-of-stream has been seen and the buffer is empty.
module prime_sink
  import prime_sink_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in__rdy,
  input  logic [W-1:0]     in__addr,
  input  logic             in__done,
  input  logic             in__take,
  output logic             out__valid,
  output logic [W-1:0]     out__dout,
  output logic [CNT_W-1:0] out__count,
  output logic [W-1:0]     out__sum,
  output logic             out__overflow,
  output logic             out__proto_err,
  output logic             out__done
);

  state_t       state;
  logic         full;
  logic         empty;
  logic [W-1:0] head;
  logic         push;
  logic         pop;

  // Once finished nothing is presented, even though the FIFO is already empty by then.
  assign out__valid = !empty && (state != ST_FINISHED);
  assign out__dout  = out__valid ? head : '0;

  // Only COLLECT accepts strobes; a full FIFO still accepts when the head leaves this cycle.
  assign pop  = !rst && out__valid && in__take;
  assign push = !rst && in__rdy && (state == ST_COLLECT) && (!full || pop);

  prime_sink_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in__addr),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Stream-control FSM together with count/sum accumulation and the sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_COLLECT;
      out__count     <= '0;
      out__sum       <= '0;
      out__overflow  <= 1'b0;
      out__proto_err <= 1'b0;
      out__done      <= 1'b0;
    end else begin
      if (push) begin
        if (out__count != '1) out__count <= out__count + 1'b1;
        out__sum <= out__sum + in__addr;
      end
      case (state)
        ST_COLLECT: begin
          if (in__rdy && full && !pop) out__overflow <= 1'b1;
          if (in__done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (in__rdy) out__proto_err <= 1'b1;
          if (empty) begin
            state     <= ST_FINISHED;
            out__done <= 1'b1;
          end
        end
        ST_FINISHED: begin
          if (in__rdy) out__proto_err <= 1'b1;
          out__done <= 1'b1;
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_sink.sv
// Directed testbench for prime_sink: prime stream, overflow, full push+pop, drain with
// protocol error, mid-stream reset and an empty stream.
module tb_prime_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in__rdy = 1'b0;
  logic [7:0] in__addr = '0;
  logic       in__done = 1'b0;
  logic       in__take = 1'b0;
  logic       out__valid;
  logic [7:0] out__dout;
  logic [7:0] out__count;
  logic [7:0] out__sum;
  logic       out__overflow;
  logic       out__proto_err;
  logic       out__done;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] got_q[$];

  localparam logic [7:0] PRIMES [25] = '{
    8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19, 8'd23, 8'd29, 8'd31, 8'd37, 8'd41,
    8'd43, 8'd47, 8'd53, 8'd59, 8'd61, 8'd67, 8'd71, 8'd73, 8'd79, 8'd83, 8'd89, 8'd97
  };

  prime_sink #(.W(8), .DEPTH(8), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in__rdy        (in__rdy),
    .in__addr       (in__addr),
    .in__done       (in__done),
    .in__take       (in__take),
    .out__valid     (out__valid),
    .out__dout      (out__dout),
    .out__count     (out__count),
    .out__sum       (out__sum),
    .out__overflow  (out__overflow),
    .out__proto_err (out__proto_err),
    .out__done      (out__done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; record any value handed over on this edge.
  task automatic applyStimulus(input logic rdy, input logic [7:0] addr, input logic take);
    in__rdy  = rdy;
    in__addr = addr;
    in__take = take;
    if (out__valid && take) got_q.push_back(out__dout);
    tick();
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in__rdy  = 1'b0;
    in__take = 1'b0;
    in__done = 1'b0;
    tick();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, out__valid, 0);
    checkOutput({tag, "_dout"}, out__dout, 0);
    checkOutput({tag, "_count"}, out__count, 0);
    checkOutput({tag, "_sum"}, out__sum, 0);
    checkOutput({tag, "_ovf"}, out__overflow, 0);
    checkOutput({tag, "_perr"}, out__proto_err, 0);
    checkOutput({tag, "_done"}, out__done, 0);
  endtask

  task automatic runPrimes(input string tag);
    int n;
    got_q.delete();
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, PRIMES[i], 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b1);
    end
    in__done = 1'b1;
    n = 0;
    while (!out__done && n < 40) begin
      applyStimulus(1'b0, 8'd0, 1'b1);
      n++;
    end
    checkOutput({tag, "_done"}, out__done, 1);
    checkOutput({tag, "_nout"}, got_q.size(), 25);
    for (int i = 0; i < 25; i++)
      if (i < got_q.size()) checkOutput({tag, "_val"}, got_q[i], PRIMES[i]);
    checkOutput({tag, "_count"}, out__count, 25);
    checkOutput({tag, "_sum"}, out__sum, 36);
    checkOutput({tag, "_ovf"}, out__overflow, 0);
    checkOutput({tag, "_perr"}, out__proto_err, 0);
    checkOutput({tag, "_valid"}, out__valid, 0);
  endtask

  initial begin
    int n;
    // Scenario 1: prime stream with continuous take
    doReset();
    checkIdle("rst");
    runPrimes("s1");

    // Scenario 2: overflow with no take, then drain
    doReset();
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("s2_ovf", out__overflow, 1);
    checkOutput("s2_count", out__count, 8);
    checkOutput("s2_sum", out__sum, 36);
    checkOutput("s2_head", out__dout, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("s2_nout", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) checkOutput("s2_val", got_q[i], i + 1);
    checkOutput("s2_empty", out__valid, 0);

    // Scenario 3: full FIFO, push and pop in the same cycle
    doReset();
    for (int i = 11; i <= 18; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b1, 8'd19, 1'b1);
    checkOutput("s3_ovf", out__overflow, 0);
    checkOutput("s3_head", out__dout, 12);
    checkOutput("s3_count", out__count, 9);
    checkOutput("s3_sum", out__sum, 135);
    n = 0;
    while (out__valid && n < 20) begin
      applyStimulus(1'b0, 8'd0, 1'b1);
      n++;
    end
    checkOutput("s3_occ", n, 8);
    checkOutput("s3_nout", got_q.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < got_q.size()) checkOutput("s3_val", got_q[i], i + 11);

    // Scenario 4: end-of-stream with 3 buffered values, strobe during drain
    doReset();
    applyStimulus(1'b1, 8'd21, 1'b0);
    applyStimulus(1'b1, 8'd22, 1'b0);
    applyStimulus(1'b1, 8'd23, 1'b0);
    in__done = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd99, 1'b0);
    checkOutput("s4_perr", out__proto_err, 1);
    checkOutput("s4_count", out__count, 3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("s4_done_early", out__done, 0);
      for (int j = 0; j < 3; j++) applyStimulus(1'b0, 8'd0, 1'b0);
    end
    checkOutput("s4_done", out__done, 1);
    checkOutput("s4_nout", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) checkOutput("s4_val", got_q[i], i + 21);
    checkOutput("s4_sum", out__sum, 66);
    checkOutput("s4_ovf", out__overflow, 0);

    // Scenario 5: reset mid-stream with data buffered and overflow set
    doReset();
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("s5_ovf_pre", out__overflow, 1);
    checkOutput("s5_head_pre", out__dout, 4);
    rst      = 1'b1;
    in__rdy  = 1'b1;
    in__addr = 8'd50;
    in__take = 1'b1;
    tick();
    rst     = 1'b0;
    in__rdy = 1'b0;
    in__take = 1'b0;
    checkIdle("s5_rst");
    runPrimes("s5");

    // Scenario 6: end-of-stream with no data
    doReset();
    in__done = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("s6_done_1", out__done, 0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("s6_done_2", out__done, 1);
    checkOutput("s6_count", out__count, 0);
    checkOutput("s6_sum", out__sum, 0);
    checkOutput("s6_valid", out__valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
